// File: rtl/wbufq_pkg.sv
// Shared defaults and the byte-merge helper for the coalescing write buffer.
package wbufq_pkg;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_AW    = 27;
  localparam int DEF_DW    = 32;

  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       take);
    return take ? new_b : old_b;
  endfunction

endpackage

// File: rtl/wbufq_if.sv
// Store, lookup and memory-drain signals of the write buffer.
interface wbufq_if
  import wbufq_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  localparam int BW   = DW / 8,
  localparam int CW   = $clog2(DEPTH) + 1
);

  // Store side: a store is taken on the edge where en & done (done is
  // combinational from buffer state). Memory side: the head write retires on
  // the edge where memen & memdone; memadr/memdata/membyteen hold until then.
  logic          en;
  logic [AW-1:0] adr;
  logic [DW-1:0] data;
  logic [BW-1:0] byteen;
  logic          done;
  logic [AW-1:0] lkadr;
  logic          lkhit;
  logic [DW-1:0] lkdata;
  logic [BW-1:0] lkbyteen;
  logic [AW-1:0] memadr;
  logic [DW-1:0] memdata;
  logic [BW-1:0] membyteen;
  logic          memen;
  logic          memdone;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  modport slave (
    input  en, adr, data, byteen, lkadr, memdone,
    output done, lkhit, lkdata, lkbyteen, memadr, memdata, membyteen,
           memen, count, full, empty
  );

  modport master (
    output en, adr, data, byteen, lkadr, memdone,
    input  done, lkhit, lkdata, lkbyteen, memadr, memdata, membyteen,
           memen, count, full, empty
  );

endinterface

// File: rtl/wbufq_entry.sv
// One write-buffer entry: address/data/byte-enable registers with load and
// byte-merge update, plus an address comparator for forwarding lookups.
module wbufq_entry
  import wbufq_pkg::*;
#(
  parameter int AW  = DEF_AW,
  parameter int DW  = DEF_DW,
  localparam int BW = DW / 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          merge,
  input  logic [AW-1:0] wadr,
  input  logic [DW-1:0] wdata,
  input  logic [BW-1:0] wbe,
  input  logic [AW-1:0] cmpadr,
  output logic [AW-1:0] q_adr,
  output logic [DW-1:0] q_data,
  output logic [BW-1:0] q_be,
  output logic          match
);

  assign match = (q_adr == cmpadr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_adr  <= '0;
      q_data <= '0;
      q_be   <= '0;
    end else if (load) begin
      q_adr  <= wadr;
      q_data <= wdata;
      q_be   <= wbe;
    end else if (merge) begin
      // Address already matches; only the enabled lanes change.
      for (int b = 0; b < BW; b++) begin
        q_data[8*b +: 8] <= merge_byte(q_data[8*b +: 8], wdata[8*b +: 8], wbe[b]);
      end
      q_be <= q_be | wbe;
    end
  end

endmodule

// File: rtl/wbufq.sv
// Coalescing write buffer: circular queue of entries drained in order to
// memory, with byte-merging into the youngest entry and read forwarding.
module wbufq
  import wbufq_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  localparam int BW   = DW / 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic  ph1,
  input  logic  resetb,
  wbufq_if.slave bus
);

  logic [PW-1:0] hp, tp, yp;
  logic [CW-1:0] count;
  logic          memen, full, merge_ok;
  logic          do_push, do_merge, do_pop;

  logic [AW-1:0] e_adr   [DEPTH];
  logic [DW-1:0] e_data  [DEPTH];
  logic [BW-1:0] e_be    [DEPTH];
  logic          e_match [DEPTH];

  assign yp    = tp - PW'(1);
  assign memen = (count != '0);
  assign full  = (count == CW'(DEPTH));

  // With count==1 the only entry is the head under issue, so it never merges.
  assign merge_ok = ((count >= CW'(2)) || ((count == CW'(1)) && !memen)) &&
                    (bus.adr == e_adr[yp]);

  assign do_push  = bus.en && !full && !merge_ok;
  assign do_merge = bus.en && merge_ok;
  assign do_pop   = memen && bus.memdone;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    wbufq_entry #(.AW(AW), .DW(DW)) u_entry (
      .clk    (ph1),
      .rst_n  (resetb),
      .load   (do_push && (tp == PW'(g))),
      .merge  (do_merge && (yp == PW'(g))),
      .wadr   (bus.adr),
      .wdata  (bus.data),
      .wbe    (bus.byteen),
      .cmpadr (bus.lkadr),
      .q_adr  (e_adr[g]),
      .q_data (e_data[g]),
      .q_be   (e_be[g]),
      .match  (e_match[g])
    );
  end

  // Walk from oldest to newest valid entry so the newest match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx          = '0;
    bus.lkhit    = 1'b0;
    bus.lkdata   = '0;
    bus.lkbyteen = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = hp + PW'(k);
      if ((CW'(k) < count) && e_match[idx]) begin
        bus.lkhit    = 1'b1;
        bus.lkdata   = e_data[idx];
        bus.lkbyteen = e_be[idx];
      end
    end
  end

  always_ff @(posedge ph1 or negedge resetb) begin
    if (!resetb) begin
      hp    <= '0;
      tp    <= '0;
      count <= '0;
    end else begin
      if (do_push) tp <= tp + PW'(1);
      if (do_pop)  hp <= hp + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.done      = !full || merge_ok;
  assign bus.memen     = memen;
  assign bus.memadr    = e_adr[hp];
  assign bus.memdata   = e_data[hp];
  assign bus.membyteen = e_be[hp];
  assign bus.count     = count;
  assign bus.full      = full;
  assign bus.empty     = (count == '0);

endmodule

// File: tb/tb_wbufq.sv
// Directed vector bench for wbufq: table of per-cycle inputs and expected
// outputs, an in-order scoreboard of retired writes, and an async-reset case.
module tb_wbufq;

  logic ph1 = 1'b0;
  logic resetb;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 ph1 = ~ph1;

  wbufq_if bus ();

  wbufq dut (
    .ph1    (ph1),
    .resetb (resetb),
    .bus    (bus)
  );

  typedef struct {
    logic        en;
    logic [26:0] adr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        md;
    logic [26:0] lk;
    logic        x_done;
    logic [2:0]  x_count;
    logic [26:0] x_madr;
    logic [31:0] x_mdata;
    logic [3:0]  x_mbe;
    logic        x_hit;
    logic [31:0] x_lkdata;
    logic [3:0]  x_lkbe;
  } vec_t;

  vec_t        vecs[$];
  logic [26:0] exp_q[$];

  task automatic add(input logic en, input logic [26:0] adr, input logic [31:0] data,
                     input logic [3:0] be, input logic md, input logic [26:0] lk,
                     input logic xd, input logic [2:0] xc, input logic [26:0] xma,
                     input logic [31:0] xmd, input logic [3:0] xmb, input logic xh,
                     input logic [31:0] xld, input logic [3:0] xlb);
    vec_t v;
    v = '{en, adr, data, be, md, lk, xd, xc, xma, xmd, xmb, xh, xld, xlb};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [26:0] adr, input logic [31:0] data,
                       input logic [3:0] be, input logic md, input logic [26:0] lk);
    bus.en      = en;
    bus.adr     = adr;
    bus.data    = data;
    bus.byteen  = be;
    bus.memdone = md;
    bus.lkadr   = lk;
  endtask

  initial begin
    resetb = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    // Fill to full, refused push, merge while full, drain in order.
    add(1,'h100,'h000000D0,'hF,0,0,      1,0,0,0,0,                 0,0,0);
    add(1,'h101,'h000000D1,'hF,0,0,      1,1,'h100,'h000000D0,'hF,  0,0,0);
    add(1,'h102,'h000000D2,'hF,0,0,      1,2,'h100,'h000000D0,'hF,  0,0,0);
    add(1,'h103,'h000000D3,'hF,0,0,      1,3,'h100,'h000000D0,'hF,  0,0,0);
    add(1,'h104,'h000000D4,'hF,0,0,      0,4,'h100,'h000000D0,'hF,  0,0,0);
    add(1,'h103,'h0000EE00,'h2,0,0,      1,4,'h100,'h000000D0,'hF,  0,0,0);
    add(1,'h104,'h000000D4,'hF,1,'h103,  0,4,'h100,'h000000D0,'hF,  1,'h0000EED3,'hF);
    add(0,0,0,0,1,'h100,                 1,3,'h101,'h000000D1,'hF,  0,0,0);
    add(0,0,0,0,1,0,                     1,2,'h102,'h000000D2,'hF,  0,0,0);
    add(0,0,0,0,1,0,                     1,1,'h103,'h0000EED3,'hF,  0,0,0);
    add(0,0,0,0,1,0,                     1,0,0,0,0,                 0,0,0);
    add(0,0,0,0,0,0,                     1,0,0,0,0,                 0,0,0);
    // Byte merge into the youngest entry.
    add(1,'h10,'h000000AA,'h1,0,0,       1,0,0,0,0,                 0,0,0);
    add(1,'h20,'h0000BB00,'h2,0,0,       1,1,'h10,'h000000AA,'h1,   0,0,0);
    add(1,'h20,'h00CC0000,'h4,0,'h20,    1,2,'h10,'h000000AA,'h1,   1,'h0000BB00,'h2);
    add(0,0,0,0,0,'h20,                  1,2,'h10,'h000000AA,'h1,   1,'h00CCBB00,'h6);
    add(0,0,0,0,1,0,                     1,2,'h10,'h000000AA,'h1,   0,0,0);
    add(0,0,0,0,1,0,                     1,1,'h20,'h00CCBB00,'h6,   0,0,0);
    // Same address while the only entry is under issue: no merge.
    add(1,'h10,'h00000001,'h1,0,0,       1,0,0,0,0,                 0,0,0);
    add(1,'h10,'h00000200,'h2,0,0,       1,1,'h10,'h00000001,'h1,   0,0,0);
    add(0,0,0,0,1,0,                     1,2,'h10,'h00000001,'h1,   0,0,0);
    add(0,0,0,0,1,0,                     1,1,'h10,'h00000200,'h2,   0,0,0);
    // Forwarding picks the newest match.
    add(1,'h30,'h11111111,'hF,0,0,       1,0,0,0,0,                 0,0,0);
    add(1,'h30,'h22222222,'hF,0,0,       1,1,'h30,'h11111111,'hF,   0,0,0);
    add(0,0,0,0,0,'h30,                  1,2,'h30,'h11111111,'hF,   1,'h22222222,'hF);
    add(0,0,0,0,0,'h31,                  1,2,'h30,'h11111111,'hF,   0,0,0);
    // Push with pop at count 2, tail wraps.
    add(1,'h40,'h44444444,'hF,1,0,       1,2,'h30,'h11111111,'hF,   0,0,0);
    add(1,'h50,'h55555555,'hF,1,0,       1,2,'h30,'h22222222,'hF,   0,0,0);
    add(1,'h60,'h66666666,'hF,1,0,       1,2,'h40,'h44444444,'hF,   0,0,0);
    add(0,0,0,0,1,'h60,                  1,2,'h50,'h55555555,'hF,   1,'h66666666,'hF);
    add(0,0,0,0,1,0,                     1,1,'h60,'h66666666,'hF,   0,0,0);
    // Merge combined with a pop.
    add(1,'h70,'h00000077,'h1,0,0,       1,0,0,0,0,                 0,0,0);
    add(1,'h71,'h71717171,'hF,0,0,       1,1,'h70,'h00000077,'h1,   0,0,0);
    add(1,'h71,'hFF000000,'h8,1,0,       1,2,'h70,'h00000077,'h1,   0,0,0);
    add(0,0,0,0,1,'h71,                  1,1,'h71,'hFF717171,'hF,   1,'hFF717171,'hF);
    add(0,0,0,0,0,0,                     1,0,0,0,0,                 0,0,0);

    exp_q = '{'h100,'h101,'h102,'h103,'h10,'h20,'h10,'h10,
              'h30,'h30,'h40,'h50,'h60,'h70,'h71};

    // Reset state.
    #12;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full",  32'(bus.full),  0);
    chk("rst_memen", 32'(bus.memen), 0);
    chk("rst_memadr", 32'(bus.memadr), 0);
    chk("rst_memdata", bus.memdata, 0);
    chk("rst_lkhit", 32'(bus.lkhit), 0);
    @(negedge ph1);
    resetb = 1'b1;

    foreach (vecs[i]) begin
      @(negedge ph1);
      drive(vecs[i].en, vecs[i].adr, vecs[i].data, vecs[i].be, vecs[i].md, vecs[i].lk);
      #2;
      chk($sformatf("v%0d_done", i),  32'(bus.done),  32'(vecs[i].x_done));
      chk($sformatf("v%0d_count", i), 32'(bus.count), 32'(vecs[i].x_count));
      chk($sformatf("v%0d_memen", i), 32'(bus.memen), 32'(vecs[i].x_count != 0));
      chk($sformatf("v%0d_full", i),  32'(bus.full),  32'(vecs[i].x_count == 4));
      chk($sformatf("v%0d_empty", i), 32'(bus.empty), 32'(vecs[i].x_count == 0));
      if (vecs[i].x_count != 0) begin
        chk($sformatf("v%0d_memadr", i),  32'(bus.memadr),    32'(vecs[i].x_madr));
        chk($sformatf("v%0d_memdata", i), bus.memdata,        vecs[i].x_mdata);
        chk($sformatf("v%0d_membe", i),   32'(bus.membyteen), 32'(vecs[i].x_mbe));
      end
      chk($sformatf("v%0d_lkhit", i),  32'(bus.lkhit),    32'(vecs[i].x_hit));
      chk($sformatf("v%0d_lkdata", i), bus.lkdata,        vecs[i].x_lkdata);
      chk($sformatf("v%0d_lkbe", i),   32'(bus.lkbyteen), 32'(vecs[i].x_lkbe));
      if (bus.memen && vecs[i].md) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("v%0d_extra_write", i), 32'(bus.memadr), 32'h7FFFFFFF);
        end else begin
          chk($sformatf("v%0d_order", i), 32'(bus.memadr), 32'(exp_q.pop_front()));
        end
      end
    end
    chk("writes_left", exp_q.size(), 0);

    // Async reset mid-drain at count 3.
    @(negedge ph1); drive(1, 'h80, 'h80808080, 'hF, 0, 0);
    @(negedge ph1); drive(1, 'h81, 'h81818181, 'hF, 0, 0);
    @(negedge ph1); drive(1, 'h82, 'h82828282, 'hF, 0, 0);
    @(negedge ph1); drive(0, 0, 0, 0, 0, 'h80);
    #2;
    chk("pre_rst_count", 32'(bus.count), 3);
    chk("pre_rst_memen", 32'(bus.memen), 1);
    chk("pre_rst_lkhit", 32'(bus.lkhit), 1);
    #1 resetb = 1'b0;
    #1;
    chk("async_memen", 32'(bus.memen), 0);
    chk("async_count", 32'(bus.count), 0);
    chk("async_empty", 32'(bus.empty), 1);
    chk("async_lkhit", 32'(bus.lkhit), 0);
    chk("async_memadr", 32'(bus.memadr), 0);
    @(negedge ph1); resetb = 1'b1;

    // First push after reset shows up at the head one cycle later.
    @(negedge ph1); drive(1, 'h90, 'h90909090, 'hF, 0, 0);
    @(negedge ph1); drive(0, 0, 0, 0, 0, 0);
    #2;
    chk("post_count", 32'(bus.count), 1);
    chk("post_memen", 32'(bus.memen), 1);
    chk("post_memadr", 32'(bus.memadr), 'h90);
    chk("post_memdata", bus.memdata, 'h90909090);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
